// File: rtl/finn_rtl_krnl_example_wr_resp_tracker.sv
// Write-response tracker: gates AW issue against an outstanding-burst limit and
// retires B responses. Optional error flag built when FINN_WR_RESP_TRACKER_ERR_EN is defined.
module finn_rtl_krnl_example_wr_resp_tracker #(
    parameter int unsigned C_BURST_CNT_WIDTH = 32,
    parameter int unsigned C_MAX_OUTSTANDING = 16,
    parameter int unsigned C_OUT_WIDTH       = $clog2(C_MAX_OUTSTANDING + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ctrl_start,
    input  logic [C_BURST_CNT_WIDTH-1:0] ctrl_num_bursts,
    output logic                         aw_allow,
    input  logic                         aw_issued,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [1:0]                   b_resp,
    output logic [C_OUT_WIDTH-1:0]       outstanding,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [C_OUT_WIDTH-1:0] MAX_OUT = C_OUT_WIDTH'(C_MAX_OUTSTANDING);

    state_e                       state_q, state_d;
    logic [C_BURST_CNT_WIDTH-1:0] issue_left_q, issue_left_d;
    logic [C_OUT_WIDTH-1:0]       outstanding_q, outstanding_d;
    logic                         issue_hs;
    logic                         b_hs;

    // Handshake qualifiers derived only from registered state
    assign aw_allow = (state_q == S_RUN) && (issue_left_q != '0) && (outstanding_q < MAX_OUT);
    assign b_ready  = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (outstanding_q != '0);
    assign issue_hs = aw_issued && aw_allow;
    assign b_hs     = b_valid && b_ready;

    assign outstanding = outstanding_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

    always_comb begin
        state_d       = state_q;
        issue_left_d  = issue_left_q;
        outstanding_d = outstanding_q;

        if (issue_hs) begin
            issue_left_d = issue_left_q - C_BURST_CNT_WIDTH'(1);
        end

        case ({issue_hs, b_hs})
            2'b10:   outstanding_d = outstanding_q + C_OUT_WIDTH'(1);
            2'b01:   outstanding_d = outstanding_q - C_OUT_WIDTH'(1);
            default: outstanding_d = outstanding_q;
        endcase

        // Transitions look at next-cycle counts so done follows the last B by one cycle
        case (state_q)
            S_IDLE: begin
                if (ctrl_start) begin
                    if (ctrl_num_bursts != '0) begin
                        state_d       = S_RUN;
                        issue_left_d  = ctrl_num_bursts;
                        outstanding_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (issue_left_d == '0) begin
                    state_d = (outstanding_d == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outstanding_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            issue_left_q  <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            issue_left_q  <= issue_left_d;
            outstanding_q <= outstanding_d;
        end
    end

`ifdef FINN_WR_RESP_TRACKER_ERR_EN
    logic err_q, err_d;

    // Sticky SLVERR/DECERR flag, cleared only by an accepted start
    always_comb begin
        err_d = err_q;
        if ((state_q == S_IDLE) && ctrl_start) begin
            err_d = 1'b0;
        end else if (b_hs && b_resp[1]) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_b_resp;
    assign unused_b_resp = ^b_resp;
    assign err           = 1'b0;
`endif

endmodule
